// File: rtl/csl_sub8_seq_if.sv
// Operand/result handshake bundle for csl_sub8_seq.
// master = producer/consumer side, slave = the subtractor.
interface csl_sub8_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             BOUT;
  logic             OVF;
  logic             ZERO;

  modport master (
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, diff, BOUT, OVF, ZERO
  );

  modport slave (
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, diff, BOUT, OVF, ZERO
  );
endinterface

// File: rtl/csl_sub8_seq.sv
// Multi-cycle carry(borrow)-select subtractor, one SLICE-bit slice per clock.
// Optional macro CSL_SUB_SATURATE_EN: clamp diff to 0 on final borrow.
module csl_sub8_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic          clk,
  input  logic          rst,
  csl_sub8_seq_if.slave bus
);
  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic [KW-1:0]    r_k;

  logic [SLICE-1:0] w_ak;
  logic [SLICE-1:0] w_bk;
  logic [SLICE-1:0] w_d0;
  logic [SLICE-1:0] w_d1;
  logic [SLICE-1:0] w_dsel;
  logic             w_b0;
  logic             w_b1;
  logic             w_bsel;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf;
  logic             w_last;

  always_comb begin
    w_ak = r_a[r_k*SLICE +: SLICE];
    w_bk = r_b[r_k*SLICE +: SLICE];
    // Both borrow-in cases computed in parallel; the extra MSB is the borrow-out.
    {w_b0, w_d0} = {1'b0, w_ak} - {1'b0, w_bk};
    {w_b1, w_d1} = {1'b0, w_ak} - {1'b0, w_bk} - {{SLICE{1'b0}}, 1'b1};
    w_dsel = r_borrow ? w_d1 : w_d0;
    w_bsel = r_borrow ? w_b1 : w_b0;
    w_acc_next = r_acc;
    w_acc_next[r_k*SLICE +: SLICE] = w_dsel;
    w_last = (r_k == KW'(NSL - 1));
    w_ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
`ifdef CSL_SUB_SATURATE_EN
    w_final = w_bsel ? '0 : w_acc_next;
`else
    w_final = w_acc_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_k      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_borrow <= bus.bin;
            r_acc    <= '0;
            r_k      <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_borrow <= w_bsel;
          r_k      <= r_k + KW'(1);
          // Partial slices live in r_acc; the visible result changes only here.
          if (w_last) begin
            r_diff  <= w_final;
            r_bout  <= w_bsel;
            r_ovf   <= w_ovf;
            r_zero  <= (w_final == '0);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.diff      = r_diff;
  assign bus.BOUT      = r_bout;
  assign bus.OVF       = r_ovf;
  assign bus.ZERO      = r_zero;
endmodule

// File: tb/tb_csl_sub8_seq.sv
// Scoreboard bench for csl_sub8_seq: driver queues hand-computed results,
// monitors check handoffs, latency, stall stability, reset and issue interval.
module tb_csl_sub8_seq;
  localparam int WIDTH = 8;
  localparam int SLICE = 4;
  localparam int NSL   = 2;
`ifdef CSL_SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csl_sub8_seq_if #(.WIDTH(WIDTH)) bus ();
  csl_sub8_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t q[$];
  int   acc_log[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_ov  = 1'b0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Handoff monitor: pops one expected result per out_valid&&out_ready edge.
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) fail_now("unexpected_result");
      else begin
        mon_e = q.pop_front();
        check("diff", {24'd0, bus.diff}, {24'd0, mon_e.d});
        check("bout_ovf_zero", {29'd0, bus.BOUT, bus.OVF, bus.ZERO},
              {29'd0, mon_e.bo, mon_e.ov, mon_e.z});
      end
    end
  end

  // Latency monitor: out_valid must rise NSL edges after the accept edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !prev_ov) begin
      if (q.size() == 0) fail_now("valid_without_pending");
      else check("latency", cyc - q[0].acc, NSL);
    end
    prev_ov <= bus.out_valid;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] d, input logic bo, input logic ov, input logic z,
                      input bit push, input bit keep);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.bin = bi; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      fail_now("accept_timeout");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_log.push_back(cyc);
    if (push) begin
      e.d   = (SAT && bo) ? 8'h00 : d;
      e.bo  = bo;
      e.ov  = ov;
      e.z   = (SAT && bo) ? 1'b1 : z;
      e.acc = cyc;
      q.push_back(e);
    end
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail_now("drain_timeout");
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ed;
    logic       ez;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_outputs", {21'd0, bus.diff, bus.BOUT, bus.OVF, bus.ZERO}, 0);
    rst = 1'b0;

    send(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0, 1, 0); drain();
    send(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1, 0); drain();
    send(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1, 0); drain();

    // Reset one cycle into an operation: it must vanish and clear outputs.
    send(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
    check("midrst_outputs", {21'd0, bus.diff, bus.BOUT, bus.OVF, bus.ZERO}, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1, 0); drain();

    send(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1, 0); drain();

    // Consumer stall: result held while out_ready stays low.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(8'h30, 8'h90, 1'b0, 8'hA0, 1'b1, 1'b1, 1'b0, 1, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_now("stall_valid_timeout");
    ed = SAT ? 8'h00 : 8'hA0;
    ez = SAT ? 1'b1 : 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_diff", {24'd0, bus.diff}, {24'd0, ed});
      check("stall_flags", {29'd0, bus.BOUT, bus.OVF, bus.ZERO}, {29'd0, 1'b1, 1'b1, ez});
      check("stall_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    send(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 0); drain();

    // Back-to-back with in_valid held high.
    acc_log.delete();
    send(8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0, 1'b0, 1, 1);
    send(8'h77, 8'h88, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1, 1);
    send(8'h9C, 8'h1C, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1, 0);
    drain();
    if (acc_log.size() == 3) begin
      check("interval_1", acc_log[1] - acc_log[0], NSL + 2);
      check("interval_2", acc_log[2] - acc_log[1], NSL + 2);
    end else fail_now("interval_accepts");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
